// File: rtl/axis_matvec_pkg.sv
// Shared types and sizing helpers for the matvec engine arbiter.
// Defaults mirror the standard engine build (4 requesters, 8x8 int8 matrix).
package axis_matvec_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int R_DEF       = 8;
  localparam int C_DEF       = 8;
  localparam int W_X_DEF     = 8;
  localparam int W_K_DEF     = 8;
  localparam int MAX_OUT_DEF = 8;

  // Result element width: product width plus accumulation growth over C terms.
  function automatic int w_y(input int w_x, input int w_k, input int c);
    return w_x + w_k + $clog2(c);
  endfunction

  localparam int W_ID     = $clog2(N_REQ_DEF);
  localparam int BUS_IN_W = R_DEF * C_DEF * W_K_DEF + C_DEF * W_X_DEF;

  typedef logic [W_ID-1:0] id_t;

  typedef enum logic {
    ARB,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/axis_matvec_tag_fifo.sv
// In-order requester-ID FIFO; push-to-head visibility is one cycle.
// Full/empty are registered; caller must not push when full or pop when empty.
module axis_matvec_tag_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      // Flags track the post-update count, so a pop while full frees the slot next cycle.
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/axis_matvec_arb.sv
// Round-robin share of one matvec engine among N_REQ AXI-Stream requesters; zero added latency.
// Grant frozen until accepted; results routed by in-order tag FIFO. AXIS_MATVEC_ARB_STATS_EN adds grant_cnt.
module axis_matvec_arb
  import axis_matvec_pkg::*;
#(
  parameter  int N_REQ   = N_REQ_DEF,
  parameter  int R       = R_DEF,
  parameter  int C       = C_DEF,
  parameter  int W_X     = W_X_DEF,
  parameter  int W_K     = W_K_DEF,
  parameter  int MAX_OUT = MAX_OUT_DEF,
  localparam int Y_W     = w_y(W_X, W_K, C),
  localparam int IN_W    = R * C * W_K + C * W_X,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ*IN_W-1:0]    s_axis_kx_tdata,
  input  logic [N_REQ-1:0]         s_axis_kx_tvalid,
  output logic [N_REQ-1:0]         s_axis_kx_tready,
  output logic [N_REQ*R*Y_W-1:0]   m_axis_y_tdata,
  output logic [N_REQ-1:0]         m_axis_y_tvalid,
  input  logic [N_REQ-1:0]         m_axis_y_tready,
  output logic [IN_W-1:0]          e_kx_tdata,
  output logic                     e_kx_tvalid,
  input  logic                     e_kx_tready,
  input  logic [R*Y_W-1:0]         e_y_tdata,
  input  logic                     e_y_tvalid,
  output logic                     e_y_tready,
  output logic                     err_orphan
`ifdef AXIS_MATVEC_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][31:0]   grant_cnt
`endif
);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] hold_g;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] rr_pick;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] head;
  logic            rr_found;
  logic            kx_hs;
  logic            pop;
  logic            full;
  logic            empty;

  always_comb begin
    rr_pick  = rr_ptr;
    rr_found = 1'b0;
    cand     = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!rr_found && s_axis_kx_tvalid[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant       = rr_pick;
    e_kx_tvalid = 1'b0;
    unique case (state)
      ARB: begin
        grant       = rr_pick;
        e_kx_tvalid = rr_found & ~full;
        if (e_kx_tvalid && !e_kx_tready) state_nxt = HOLD;
      end
      HOLD: begin
        // Offered beat must stay stable, so ignore newer higher-priority requesters.
        grant       = hold_g;
        e_kx_tvalid = ~full;
        if (e_kx_tvalid && e_kx_tready) state_nxt = ARB;
      end
    endcase
  end

  assign kx_hs      = e_kx_tvalid & e_kx_tready;
  assign e_kx_tdata = s_axis_kx_tdata[int'(grant)*IN_W +: IN_W];

  always_comb begin
    s_axis_kx_tready = '0;
    if (e_kx_tvalid) s_axis_kx_tready[grant] = e_kx_tready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ARB;
      rr_ptr     <= '0;
      hold_g     <= '0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB) hold_g <= grant;
      if (kx_hs) rr_ptr <= (grant == ID_W'(N_REQ-1)) ? '0 : grant + 1'b1;
      if (e_y_tvalid && empty) err_orphan <= 1'b1;
    end
  end

  axis_matvec_tag_fifo #(
    .W     (ID_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (kx_hs),
    .din   (grant),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign e_y_tready     = ~empty & m_axis_y_tready[head];
  assign pop            = e_y_tvalid & e_y_tready;
  assign m_axis_y_tdata = {N_REQ{e_y_tdata}};

  always_comb begin
    m_axis_y_tvalid       = '0;
    m_axis_y_tvalid[head] = e_y_tvalid & ~empty;
  end

`ifdef AXIS_MATVEC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_cnt <= '0;
    end else if (kx_hs) begin
      grant_cnt[grant] <= grant_cnt[grant] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_matvec_arb.sv
// Directed and randomised bench for axis_matvec_arb with a behavioural engine model.
// Inputs change only on the falling edge; handshakes are evaluated just before the rising edge.
module tb_axis_matvec_arb;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int C  = 8;
  localparam int WX = 8;
  localparam int WK = 8;
  localparam int MO = 8;
  localparam int WY = WX + WK + $clog2(C);
  localparam int IW = R * C * WK + C * WX;
  localparam int YW = R * WY;

  typedef struct packed {
    logic [1:0]    id;
    logic [YW-1:0] y;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N*IW-1:0] s_tdata = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [N*YW-1:0] m_tdata;
  logic [N-1:0]    m_tvalid;
  logic [N-1:0]    m_tready = '0;
  logic [IW-1:0]   e_kx_tdata;
  logic            e_kx_tvalid;
  logic            e_kx_tready = 1'b0;
  logic [YW-1:0]   e_y_tdata = '0;
  logic            e_y_tvalid = 1'b0;
  logic            e_y_tready;
  logic            err_orphan;
`ifdef AXIS_MATVEC_ARB_STATS_EN
  logic [N-1:0][31:0] grant_cnt;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  logic [YW-1:0] eng_q[$];
  exp_t          exp_q[$];
  int            gseq[$];
  int            dlv_cnt[N];
  int            acc_cnt = 0;
  logic          auto_src = 1'b0;
  int            idle_pct = 0;
  logic          rand_rdy = 1'b0;
  logic          eng_y_en = 1'b0;
  logic          y_pend = 1'b0;

  axis_matvec_arb #(
    .N_REQ(N), .R(R), .C(C), .W_X(WX), .W_K(WK), .MAX_OUT(MO)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .s_axis_kx_tdata  (s_tdata),
    .s_axis_kx_tvalid (s_tvalid),
    .s_axis_kx_tready (s_tready),
    .m_axis_y_tdata   (m_tdata),
    .m_axis_y_tvalid  (m_tvalid),
    .m_axis_y_tready  (m_tready),
    .e_kx_tdata       (e_kx_tdata),
    .e_kx_tvalid      (e_kx_tvalid),
    .e_kx_tready      (e_kx_tready),
    .e_y_tdata        (e_y_tdata),
    .e_y_tvalid       (e_y_tvalid),
    .e_y_tready       (e_y_tready),
    .err_orphan       (err_orphan)
`ifdef AXIS_MATVEC_ARB_STATS_EN
    ,
    .grant_cnt        (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  // Reference engine: y[r] = sum_c signed(K[r][c]) * signed(x[c]); K above x in the beat.
  function automatic logic [YW-1:0] golden(input logic [IW-1:0] p);
    logic [YW-1:0] y;
    int acc, kv, xv;
    y = '0;
    for (int r = 0; r < R; r++) begin
      acc = 0;
      for (int c = 0; c < C; c++) begin
        kv = $signed(p[C*WX + (r*C+c)*WK +: WK]);
        xv = $signed(p[c*WX +: WX]);
        acc += kv * xv;
      end
      y[r*WY +: WY] = acc[WY-1:0];
    end
    return y;
  endfunction

  function automatic logic [IW-1:0] rand_pkt();
    logic [IW-1:0] p;
    p = '0;
    for (int i = 0; i < IW/32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic eng_drive();
    if (!y_pend) begin
      e_y_tvalid = eng_y_en && (eng_q.size() != 0);
      if (e_y_tvalid) e_y_tdata = eng_q[0];
    end
  endtask

  // One clock: score the handshakes about to happen, cross the edge, then update sources/engine.
  task automatic cyc();
    logic          kx_hs, y_hs;
    logic [N-1:0]  s_hs;
    int            g, found;
    #1;
    kx_hs = e_kx_tvalid && e_kx_tready;
    y_hs  = e_y_tvalid && e_y_tready;
    s_hs  = s_tvalid & s_tready;
    if (kx_hs) begin
      n_vec++;
      if ($countones(s_hs) != 1) begin
        n_err++;
        $display("FAIL kx_grant s_tready=%b s_tvalid=%b, want exactly one granted valid", s_tready, s_tvalid);
      end else begin
        g = 0;
        for (int i = 0; i < N; i++) if (s_hs[i]) g = i;
        n_vec++;
        if (e_kx_tdata !== s_tdata[g*IW +: IW]) begin
          n_err++;
          $display("FAIL kx_data req%0d engine beat differs from requester beat", g);
        end
        eng_q.push_back(golden(e_kx_tdata));
        exp_q.push_back('{id: 2'(g), y: golden(s_tdata[g*IW +: IW])});
        gseq.push_back(g);
        acc_cnt++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_tvalid[i] && m_tready[i]) begin
        n_vec++;
        found = -1;
        for (int j = 0; j < exp_q.size(); j++)
          if (found < 0 && int'(exp_q[j].id) == i) found = j;
        if (found < 0) begin
          n_err++;
          $display("FAIL deliver_unexpected req%0d got %h, expected nothing", i, m_tdata[i*YW +: YW]);
        end else begin
          if (m_tdata[i*YW +: YW] !== exp_q[found].y) begin
            n_err++;
            $display("FAIL deliver_data req%0d got %h want %h", i, m_tdata[i*YW +: YW], exp_q[found].y);
          end
          exp_q.delete(found);
          dlv_cnt[i]++;
        end
      end
    end
    if (y_hs) eng_q.delete(0);
    y_pend = e_y_tvalid && !y_hs;
    @(posedge clk);
    @(negedge clk);
    if (rand_rdy) begin
      e_kx_tready = ($urandom_range(0, 99) >= 10);
      eng_y_en    = ($urandom_range(0, 99) >= 10);
      for (int i = 0; i < N; i++) m_tready[i] = ($urandom_range(0, 99) >= 10);
    end
    eng_drive();
    for (int i = 0; i < N; i++) begin
      if (s_hs[i]) s_tvalid[i] = 1'b0;
      if (auto_src && !s_tvalid[i] && ($urandom_range(0, 99) >= idle_pct)) begin
        s_tdata[i*IW +: IW] = rand_pkt();
        s_tvalid[i] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    s_tvalid = '0; m_tready = '0; e_kx_tready = 1'b0; e_y_tvalid = 1'b0;
    auto_src = 1'b0; rand_rdy = 1'b0; eng_y_en = 1'b0; y_pend = 1'b0; idle_pct = 0;
    eng_q.delete(); exp_q.delete(); gseq.delete();
    acc_cnt = 0;
    for (int i = 0; i < N; i++) dlv_cnt[i] = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    auto_src = 1'b0; rand_rdy = 1'b0;
    e_kx_tready = 1'b1; m_tready = '1; eng_y_en = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      cyc();
      ok = (s_tvalid == '0) && (exp_q.size() == 0) && (eng_q.size() == 0) && !e_y_tvalid;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    n_vec++; if (s_tready !== 4'b0000) begin n_err++; $display("FAIL reset_s_tready got %b want 0000", s_tready); end
    n_vec++; if (e_kx_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_e_kx_tvalid got %b want 0", e_kx_tvalid); end
    n_vec++; if (m_tvalid !== 4'b0000) begin n_err++; $display("FAIL reset_m_tvalid got %b want 0000", m_tvalid); end
    n_vec++; if (e_y_tready !== 1'b0) begin n_err++; $display("FAIL reset_e_y_tready got %b want 0", e_y_tready); end
    n_vec++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL reset_err_orphan got %b want 0", err_orphan); end
  endtask

  task automatic test_rr_order();
    bit ok;
    int total;
    do_reset();
    e_kx_tready = 1'b1; m_tready = '1; eng_y_en = 1'b1;
    for (int i = 0; i < N; i++) s_tdata[i*IW +: IW] = rand_pkt();
    s_tvalid = '1;
    auto_src = 1'b1;
    for (int k = 0; k < 40 && gseq.size() < 8; k++) cyc();
    n_vec++;
    if (gseq.size() < 8) begin
      n_err++; $display("FAIL rr_count got %0d grants want 8", gseq.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (gseq[k] != k % N) begin
          n_err++; $display("FAIL rr_order grant #%0d got req%0d want req%0d", k, gseq[k], k % N);
        end
      end
    end
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rr_drain outstanding=%0d want 0", exp_q.size()); end
    total = 0;
    for (int i = 0; i < N; i++) total += dlv_cnt[i];
    n_vec++; if (total != acc_cnt) begin n_err++; $display("FAIL rr_deliveries got %0d want %0d", total, acc_cnt); end
  endtask

  task automatic test_hold();
    bit ok;
    logic [IW-1:0] pkt0, pkt2, pkt3;
    do_reset();
    m_tready = '1; eng_y_en = 1'b1; e_kx_tready = 1'b0;
    pkt0 = rand_pkt(); pkt2 = rand_pkt(); pkt3 = rand_pkt();
    s_tdata[2*IW +: IW] = pkt2;
    s_tvalid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin s_tdata[0 +: IW] = pkt0; s_tvalid[0] = 1'b1; end
      #1;
      n_vec++; if (e_kx_tvalid !== 1'b1) begin n_err++; $display("FAIL hold_tvalid cyc%0d got %b want 1", c, e_kx_tvalid); end
      n_vec++; if (e_kx_tdata !== pkt2) begin n_err++; $display("FAIL hold_data cyc%0d engine beat is not req2 packet", c); end
      n_vec++; if (s_tready !== 4'b0000) begin n_err++; $display("FAIL hold_s_tready cyc%0d got %b want 0000", c, s_tready); end
      cyc();
    end
    s_tdata[3*IW +: IW] = pkt3;
    s_tvalid[3] = 1'b1;
    e_kx_tready = 1'b1;
    #1;
    n_vec++; if (s_tready !== 4'b0100) begin n_err++; $display("FAIL hold_release got %b want 0100", s_tready); end
    cyc();
    #1;
    n_vec++; if (s_tready !== 4'b1000) begin n_err++; $display("FAIL hold_next3 got %b want 1000", s_tready); end
    n_vec++; if (e_kx_tdata !== pkt3) begin n_err++; $display("FAIL hold_next3_data engine beat is not req3 packet"); end
    cyc();
    #1;
    n_vec++; if (s_tready !== 4'b0001) begin n_err++; $display("FAIL hold_next0 got %b want 0001", s_tready); end
    n_vec++; if (e_kx_tdata !== pkt0) begin n_err++; $display("FAIL hold_next0_data engine beat is not req0 packet"); end
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL hold_drain outstanding=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_full();
    bit ok;
    do_reset();
    e_kx_tready = 1'b1; m_tready = '1; eng_y_en = 1'b0;
    auto_src = 1'b1;
    for (int k = 0; k < 40 && acc_cnt < MO; k++) cyc();
    repeat (3) cyc();
    n_vec++; if (acc_cnt != MO) begin n_err++; $display("FAIL full_accepts got %0d want %0d", acc_cnt, MO); end
    #1;
    n_vec++; if (e_kx_tvalid !== 1'b0) begin n_err++; $display("FAIL full_block got %b want 0", e_kx_tvalid); end
    n_vec++; if (s_tready !== 4'b0000) begin n_err++; $display("FAIL full_s_tready got %b want 0000", s_tready); end
    eng_y_en = 1'b1;
    eng_drive();
    #1;
    n_vec++; if (e_y_tready !== 1'b1) begin n_err++; $display("FAIL full_pop_ready got %b want 1", e_y_tready); end
    n_vec++; if (e_kx_tvalid !== 1'b0) begin n_err++; $display("FAIL full_pop_same_cycle got %b want 0", e_kx_tvalid); end
    eng_y_en = 1'b0;
    cyc();
    #1;
    n_vec++; if (e_kx_tvalid !== 1'b1) begin n_err++; $display("FAIL full_resume got %b want 1", e_kx_tvalid); end
    cyc();
    n_vec++; if (acc_cnt != MO + 1) begin n_err++; $display("FAIL full_ninth got %0d accepts want %0d", acc_cnt, MO + 1); end
    #1;
    n_vec++; if (e_kx_tvalid !== 1'b0) begin n_err++; $display("FAIL full_again got %b want 0", e_kx_tvalid); end
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL full_drain outstanding=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_resp_block();
    bit ok;
    logic [IW-1:0] pk;
    logic [YW-1:0] exp_y;
    do_reset();
    pk = '0;
    for (int c = 0; c < C; c++) pk[c*WX +: WX] = 8'(c + 1);
    for (int r = 0; r < R*C; r++) pk[C*WX + r*WK +: WK] = 8'hFF;
    // Every row: -(1+2+...+8) = -36 in 19-bit two's complement.
    for (int r = 0; r < R; r++) exp_y[r*WY +: WY] = 19'h7FFDC;
    e_kx_tready = 1'b1; m_tready = 4'b1101; eng_y_en = 1'b1;
    s_tdata[1*IW +: IW] = pk;
    s_tvalid = 4'b0010;
    cyc();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (e_y_tvalid !== 1'b1) begin n_err++; $display("FAIL resp_y_valid cyc%0d got %b want 1", c, e_y_tvalid); end
      n_vec++; if (e_y_tready !== 1'b0) begin n_err++; $display("FAIL resp_y_ready cyc%0d got %b want 0", c, e_y_tready); end
      n_vec++; if (m_tvalid !== 4'b0010) begin n_err++; $display("FAIL resp_m_tvalid cyc%0d got %b want 0010", c, m_tvalid); end
      cyc();
    end
    m_tready[1] = 1'b1;
    #1;
    n_vec++; if (e_y_tready !== 1'b1) begin n_err++; $display("FAIL resp_release got %b want 1", e_y_tready); end
    n_vec++; if (m_tdata[1*YW +: YW] !== exp_y) begin n_err++; $display("FAIL resp_dot got %h want %h", m_tdata[1*YW +: YW], exp_y); end
    cyc();
    #1;
    n_vec++; if (dlv_cnt[1] != 1) begin n_err++; $display("FAIL resp_single got %0d deliveries want 1", dlv_cnt[1]); end
    n_vec++; if (m_tvalid !== 4'b0000) begin n_err++; $display("FAIL resp_after got %b want 0000", m_tvalid); end
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL resp_drain outstanding=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_orphan();
    do_reset();
    m_tready = '1;
    e_y_tdata = {5{$urandom}};
    e_y_tvalid = 1'b1;
    #1;
    n_vec++; if (e_y_tready !== 1'b0) begin n_err++; $display("FAIL orphan_ready got %b want 0", e_y_tready); end
    n_vec++; if (m_tvalid !== 4'b0000) begin n_err++; $display("FAIL orphan_m_tvalid got %b want 0000", m_tvalid); end
    n_vec++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL orphan_early got %b want 0", err_orphan); end
    @(posedge clk);
    @(negedge clk);
    e_y_tvalid = 1'b0;
    #1;
    n_vec++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_set got %b want 1", err_orphan); end
    repeat (3) @(negedge clk);
    n_vec++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_sticky got %b want 1", err_orphan); end
    rstn = 1'b0;
    #1;
    n_vec++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL orphan_clear got %b want 0", err_orphan); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_random();
    bit ok;
    int total;
    do_reset();
    idle_pct = 10; rand_rdy = 1'b1; auto_src = 1'b1;
    e_kx_tready = 1'b1; m_tready = '1; eng_y_en = 1'b1;
    for (int k = 0; k < 8000 && acc_cnt < 500; k++) cyc();
    n_vec++; if (acc_cnt < 500) begin n_err++; $display("FAIL rand_accepts got %0d want >=500", acc_cnt); end
    drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rand_drain outstanding=%0d want 0", exp_q.size()); end
    total = 0;
    for (int i = 0; i < N; i++) total += dlv_cnt[i];
    n_vec++; if (total != acc_cnt) begin n_err++; $display("FAIL rand_deliveries got %0d want %0d", total, acc_cnt); end
    n_vec++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL rand_orphan got %b want 0", err_orphan); end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_hold();
    test_full();
    test_resp_block();
    test_orphan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
